// File: rtl/lc3_wait_memory_if.sv
// Request/response bus between an LC-3 style requester and lc3_wait_memory.
interface lc3_wait_memory_if #(
  parameter int AddrBusSize = 16,
  parameter int ElementSize = 16
);
  logic                   i_write_en;
  logic                   i_read_en;
  logic [AddrBusSize-1:0] i_write_addr;
  logic [AddrBusSize-1:0] i_read_addr;
  logic [ElementSize-1:0] i_write_data;
  logic [ElementSize-1:0] o_read_data;
  logic                   o_Ready_Bit;

  modport master (
    output i_write_en, i_read_en, i_write_addr, i_read_addr, i_write_data,
    input  o_read_data, o_Ready_Bit
  );

  modport slave (
    input  i_write_en, i_read_en, i_write_addr, i_read_addr, i_write_data,
    output o_read_data, o_Ready_Bit
  );
endinterface

// File: rtl/lc3_wait_memory.sv
// Fixed-latency word memory with a one-cycle ready strobe (LC-3 R signal).
// Optional display registers (DSR 0xFE04 / DDR 0xFE06) under MEM_MMIO_DISPLAY_EN.
module lc3_wait_memory #(
  parameter              INIT_FILE   = "",
  parameter int          AddrBusSize = 16,
  parameter int          NumElements = 512,
  parameter int          ElementSize = 16,
  parameter int          WaitStates  = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  lc3_wait_memory_if.slave  bus,
  output logic [7:0]        o_DDR_Data,
  output logic              o_DDR_Valid
);
  localparam int IdxW = (NumElements > 1) ? $clog2(NumElements) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_is_wr;
  logic [AddrBusSize-1:0] r_addr;
  logic [ElementSize-1:0] r_wdata;
  logic [ElementSize-1:0] r_read_data;
  logic                   r_ready;
  logic [ElementSize-1:0] r_mem [NumElements];

  logic                   w_access;
  logic                   w_in_range;
  logic [IdxW-1:0]        w_idx;
  logic [ElementSize-1:0] w_rd_val;
  logic                   w_mem_we;

  assign w_access   = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_in_range = ({1'b0, r_addr} < (AddrBusSize+1)'(NumElements));
  assign w_idx      = r_addr[IdxW-1:0];

`ifdef MEM_MMIO_DISPLAY_EN
  logic       w_is_dsr;
  logic       w_is_ddr;
  logic [7:0] r_ddr_data;
  logic       r_ddr_valid;

  assign w_is_dsr = (r_addr == AddrBusSize'(16'hFE04));
  assign w_is_ddr = (r_addr == AddrBusSize'(16'hFE06));

  always_comb begin
    w_rd_val = '0;
    if (w_is_dsr)        w_rd_val = ElementSize'(16'h8000);
    else if (w_is_ddr)   w_rd_val = ElementSize'(r_ddr_data);
    else if (w_in_range) w_rd_val = r_mem[w_idx];
  end

  // The strobe is set on the same edge as ready, so both are high in one cycle.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_ddr_data  <= 8'd0;
      r_ddr_valid <= 1'b0;
    end else begin
      r_ddr_valid <= w_access && r_is_wr && w_is_ddr;
      if (w_access && r_is_wr && w_is_ddr) r_ddr_data <= r_wdata[7:0];
    end
  end

  assign o_DDR_Data  = r_ddr_data;
  assign o_DDR_Valid = r_ddr_valid;
  assign w_mem_we    = w_access && r_is_wr && w_in_range && !w_is_ddr && !w_is_dsr && !i_RST;
`else
  always_comb begin
    w_rd_val = '0;
    if (w_in_range) w_rd_val = r_mem[w_idx];
  end

  assign o_DDR_Data  = 8'd0;
  assign o_DDR_Valid = 1'b0;
  assign w_mem_we    = w_access && r_is_wr && w_in_range && !i_RST;
`endif

  // No reset on the array: contents survive reset, and an aborted write never lands.
  always_ff @(posedge i_CLK) begin
    if (w_mem_we) r_mem[w_idx] <= r_wdata;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          // Write has priority when both enables are high.
          if (bus.i_write_en || bus.i_read_en) begin
            r_is_wr <= bus.i_write_en;
            r_addr  <= bus.i_write_en ? bus.i_write_addr : bus.i_read_addr;
            r_wdata <= bus.i_write_data;
            r_cnt   <= 4'(WaitStates - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            if (!r_is_wr) r_read_data <= w_rd_val;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_read_data = r_read_data;
  assign bus.o_Ready_Bit = r_ready;
endmodule

// File: tb/tb_lc3_wait_memory.sv
// Scoreboard bench for lc3_wait_memory: expected completions queued at the
// sampling edge, retired when their ready cycle comes around.
module tb_lc3_wait_memory;
  localparam int WS = 4;
  localparam int NE = 512;

  typedef struct {
    string       tag;
    int          due;
    bit          is_rd;
    bit          ddr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ddr_data;
  logic        ddr_valid;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic [15:0] last_rd = 16'h0;
  logic [7:0]  ddr_model = 8'h0;
  logic [15:0] model [int];
  exp_t        sb [$];
  exp_t        mon_e;
  bit          exp_rdy;
  bit          exp_ddr;

  lc3_wait_memory_if #(.AddrBusSize(16), .ElementSize(16)) bus ();

  lc3_wait_memory #(
    .INIT_FILE(""), .AddrBusSize(16), .NumElements(NE), .ElementSize(16), .WaitStates(WS)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .bus(bus), .o_DDR_Data(ddr_data), .o_DDR_Valid(ddr_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [15:0] a);
`ifdef MEM_MMIO_DISPLAY_EN
    if (a == 16'hFE04) return 16'h8000;
    if (a == 16'hFE06) return {8'h00, ddr_model};
`endif
    if (a >= 16'(NE)) return 16'h0000;
    return model.exists(int'(a)) ? model[int'(a)] : 16'hxxxx;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_rdy = (sb.size() > 0) && (sb[0].due == cyc);
      exp_ddr = exp_rdy && sb[0].ddr;
      chk("ready", bus.o_Ready_Bit, exp_rdy);
      chk("ddr_valid", ddr_valid, exp_ddr);
      if (exp_rdy) begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd) begin
          chk(mon_e.tag, bus.o_read_data, mon_e.data);
          last_rd = mon_e.data;
        end else begin
          chk({mon_e.tag, "_hold"}, bus.o_read_data, last_rd);
        end
        if (mon_e.ddr) chk("ddr_data", ddr_data, mon_e.data[7:0]);
      end
    end
  end

  // Enqueue the expected completion for an access sampled at the edge just passed.
  task automatic push(input string tag, input bit we, input logic [15:0] wa,
                      input logic [15:0] ra, input logic [15:0] wd, input int due);
    exp_t e;
    e.tag = tag; e.due = due; e.is_rd = !we; e.ddr = 1'b0; e.data = wd;
    if (we) begin
`ifdef MEM_MMIO_DISPLAY_EN
      if (wa == 16'hFE06) begin e.ddr = 1'b1; ddr_model = wd[7:0]; end
      else
`endif
      if (wa < 16'(NE)) model[int'(wa)] = wd;
    end else begin
      e.data = exp_read(ra);
    end
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic access(input string tag, input bit we, input bit re, input logic [15:0] wa,
                        input logic [15:0] ra, input logic [15:0] wd, input bit now);
    if (!now) @(negedge clk);
    bus.i_write_en = we; bus.i_read_en = re;
    bus.i_write_addr = wa; bus.i_read_addr = ra; bus.i_write_data = wd;
    @(posedge clk); #1;
    push(tag, we, wa, ra, wd, cyc + WS);
    // Garbage on the bus during BUSY must not matter.
    bus.i_write_en = 1'b0; bus.i_read_en = 1'b0;
    bus.i_write_addr = 16'($urandom); bus.i_read_addr = 16'($urandom);
    bus.i_write_data = 16'($urandom);
    wait_done();
  endtask

  initial begin
    int n;
    logic [15:0] a, d;
    bus.i_write_en = 1'b0; bus.i_read_en = 1'b0;
    bus.i_write_addr = '0; bus.i_read_addr = '0; bus.i_write_data = '0;
    #1;
    chk("rst_ready", bus.o_Ready_Bit, 1'b0);
    chk("rst_rdata", bus.o_read_data, 16'h0);
    chk("rst_ddr_data", ddr_data, 8'h0);
    chk("rst_ddr_valid", ddr_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    access("wr10", 1, 0, 16'h0010, 16'h0000, 16'h1234, 0);
    access("rd10", 0, 1, 16'h0000, 16'h0010, 16'h0000, 0);
    access("both_wr", 1, 1, 16'h0005, 16'h0006, 16'hBEEF, 0);
    access("rd5", 0, 1, 16'h0000, 16'h0005, 16'h0000, 0);
    access("rd_oor", 0, 1, 16'h0000, 16'h0200, 16'h0000, 0);
    access("wr_oor", 1, 0, 16'h0205, 16'h0000, 16'hDEAD, 0);
    access("rd5_again", 0, 1, 16'h0000, 16'h0005, 16'h0000, 0);
    access("rd_dsr", 0, 1, 16'h0000, 16'hFE04, 16'h0000, 0);
    access("wr_ddr", 1, 0, 16'hFE06, 16'h0000, 16'h0041, 0);
    access("rd_ddr", 0, 1, 16'h0000, 16'hFE06, 16'h0000, 0);

    // Enable held through ready: next access is sampled two edges after completion.
    @(negedge clk);
    bus.i_read_en = 1'b1; bus.i_read_addr = 16'h0010;
    @(posedge clk); #1;
    n = cyc;
    push("b2b_1", 0, 16'h0, 16'h0010, 16'h0, n + WS);
    push("b2b_2", 0, 16'h0, 16'h0010, 16'h0, n + 2*WS + 2);
    repeat (WS + 2) @(posedge clk);
    #1 bus.i_read_en = 1'b0;
    wait_done();

    for (int i = 0; i < 6; i++) begin
      a = 16'(16'h0040 + $urandom_range(0, 63));
      d = 16'($urandom);
      access("rnd_wr", 1, 0, a, 16'h0, d, 0);
      access("rnd_rd", 0, 1, 16'h0, a, 16'h0, 0);
    end

    // Abort a write with reset partway through BUSY.
    access("pre_wr20", 1, 0, 16'h0020, 16'h0, 16'h1111, 0);
    access("pre_rd20", 0, 1, 16'h0, 16'h0020, 16'h0, 0);
    @(negedge clk);
    bus.i_write_en = 1'b1; bus.i_write_addr = 16'h0020; bus.i_write_data = 16'h2222;
    @(posedge clk); #1 bus.i_write_en = 1'b0;
    @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_ready", bus.o_Ready_Bit, 1'b0);
    chk("arst_rdata", bus.o_read_data, 16'h0);
    chk("arst_ddr_data", ddr_data, 8'h0);
    last_rd = 16'h0;
    @(negedge clk); #2 rst = 1'b0;
    access("rd20_after_abort", 0, 1, 16'h0, 16'h0020, 16'h0, 1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
